pixel_row_tx: RTL and testbench

Row-to-bus transmitter for the pixel sensor readout path. It accepts one complete digitized row of `PIXEL_ARRAY_WIDTH` pixels at a time and emits it on the `OUTPUT_BUS_WIDTH`-pixel output bus as `PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH` beats, using a valid/ready handshake. It tracks row and frame position and marks frame start, row end and frame end on the bus. It sits between the pixel array / ADC row latch and the output bus consumer.

---
 rtl/pixel_row_tx.sv | 179 +++++++++++++++++
 tb/tb_pixel_row_tx.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_tx.sv
// rtl/pixel_row_tx.sv - row-to-bus pixel transmitter with frame/row markers
// Optional feature macro: PIXEL_TX_PARITY_EN adds out_parity (XOR of out_data).
module pixel_row_tx #(
  parameter int PIXEL_ARRAY_HEIGHT = 3,
  parameter int PIXEL_ARRAY_WIDTH  = 24,
  parameter int PIXEL_BITS         = 8,
  parameter int OUTPUT_BUS_WIDTH   = 8,
  parameter int BEATS              = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     row_valid,
  output logic                                     row_ready,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]  row_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0]   out_data,
  output logic                                     out_sof,
  output logic                                     out_eol,
  output logic                                     out_eof,
  output logic [15:0]                              frame_count
`ifdef PIXEL_TX_PARITY_EN
  , output logic                                   out_parity
`endif
);

  localparam int ROW_W  = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
  localparam int BEAT_W = OUTPUT_BUS_WIDTH * PIXEL_BITS;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW     = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(PIXEL_ARRAY_HEIGHT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [RW-1:0]       row_q, row_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic [ROW_W-1:0]    buf_q, buf_d;
  logic                out_valid_q, out_valid_d;
  logic [BEAT_W-1:0]   out_data_q, out_data_d;
  logic                out_sof_q, out_sof_d;
  logic                out_eol_q, out_eol_d;
  logic                out_eof_q, out_eof_d;

  logic                accept;
  logic                fire;
  logic                last_beat;
  logic [RW-1:0]       row_next;

  function automatic logic [BEAT_W-1:0] beat_slice(input logic [ROW_W-1:0] r,
                                                   input logic [BW-1:0]    idx);
    return r[int'(idx)*BEAT_W +: BEAT_W];
  endfunction

  // Only combinational output: a row can enter while idle, or in the same
  // cycle the last beat of the current row is taken by the consumer.
  assign last_beat = (beat_q == LAST_BEAT);
  assign row_ready = (state_q == IDLE) || ((state_q == SEND) && last_beat && out_ready);
  assign accept    = row_valid && row_ready;
  assign fire      = out_valid_q && out_ready;
  assign row_next  = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);

  // Next-state, position tracking and next registered beat contents.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    row_d         = row_q;
    frame_count_d = frame_count_q;
    buf_d         = buf_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sof_d     = out_sof_q;
    out_eol_d     = out_eol_q;
    out_eof_d     = out_eof_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SEND;
          buf_d       = row_data;
          beat_d      = '0;
          out_valid_d = 1'b1;
          out_data_d  = beat_slice(row_data, '0);
          out_sof_d   = (row_q == '0);
          out_eol_d   = (LAST_BEAT == '0);
          out_eof_d   = out_eol_d && (row_q == LAST_ROW);
        end
      end
      SEND: begin
        if (fire) begin
          if (last_beat) begin
            row_d  = row_next;
            beat_d = '0;
            if (row_q == LAST_ROW) begin
              frame_count_d = frame_count_q + 16'd1;
            end
            if (accept) begin
              buf_d       = row_data;
              out_data_d  = beat_slice(row_data, '0);
              out_sof_d   = (row_next == '0);
              out_eol_d   = (LAST_BEAT == '0);
              out_eof_d   = out_eol_d && (row_next == LAST_ROW);
            end else begin
              // Data is left as-is while idle; only valid and markers drop.
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_sof_d   = 1'b0;
              out_eol_d   = 1'b0;
              out_eof_d   = 1'b0;
            end
          end else begin
            beat_d     = beat_q + BW'(1);
            out_data_d = beat_slice(buf_q, beat_d);
            out_sof_d  = 1'b0;
            out_eol_d  = (beat_d == LAST_BEAT);
            out_eof_d  = out_eol_d && (row_q == LAST_ROW);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any partial row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      row_q         <= '0;
      frame_count_q <= '0;
      buf_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sof_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      out_eof_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      row_q         <= row_d;
      frame_count_q <= frame_count_d;
      buf_q         <= buf_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sof_q     <= out_sof_d;
      out_eol_q     <= out_eol_d;
      out_eof_q     <= out_eof_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sof     = out_sof_q;
  assign out_eol     = out_eol_q;
  assign out_eof     = out_eof_q;
  assign frame_count = frame_count_q;

`ifdef PIXEL_TX_PARITY_EN
  logic out_parity_q, out_parity_d;

  assign out_parity_d = ^out_data_d;

  // Parity travels with out_data so it holds under backpressure as well.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_parity_q <= 1'b0;
    end else begin
      out_parity_q <= out_parity_d;
    end
  end

  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_pixel_row_tx.sv
// tb/tb_pixel_row_tx.sv - self-checking bench for pixel_row_tx
module tb_pixel_row_tx;

  localparam int H      = 3;
  localparam int NBEATS = 3;
  localparam int ROW_W  = 24 * 8;
  localparam int BEAT_W = 8 * 8;

  logic              clk;
  logic              reset;
  logic              row_valid;
  logic              row_ready;
  logic [ROW_W-1:0]  row_data;
  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] out_data;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;
  logic [15:0]       frame_count;
`ifdef PIXEL_TX_PARITY_EN
  logic              out_parity;
`endif

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic              sof;
    logic              eol;
    logic              eof;
    logic              par;
  } beat_t;

  beat_t sb[$];
  int    model_row;
  int    tests;
  int    fails;
  int    cyc;

  pixel_row_tx dut (
    .clk         (clk),
    .reset       (reset),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .out_eof     (out_eof),
    .frame_count (frame_count)
`ifdef PIXEL_TX_PARITY_EN
    , .out_parity (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used for latency/throughput checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every accepted beat is popped and compared.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      tests = tests + 1;
      if (sb.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_beat got data=%h with empty scoreboard", out_data);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (out_data !== e.data || out_sof !== e.sof || out_eol !== e.eol || out_eof !== e.eof) begin
          fails = fails + 1;
          $display("FAIL beat got data=%h sof=%b eol=%b eof=%b exp data=%h sof=%b eol=%b eof=%b",
                   out_data, out_sof, out_eol, out_eof, e.data, e.sof, e.eol, e.eof);
        end
`ifdef PIXEL_TX_PARITY_EN
        tests = tests + 1;
        if (out_parity !== e.par) begin
          fails = fails + 1;
          $display("FAIL beat_parity got %b exp %b", out_parity, e.par);
        end
`endif
      end
    end
  end

  function automatic logic [ROW_W-1:0] make_row(input int base);
    logic [ROW_W-1:0] d;
    for (int i = 0; i < 24; i++) d[i*8 +: 8] = 8'(base + i);
    return d;
  endfunction

  task automatic push_row(input logic [ROW_W-1:0] d);
    beat_t e;
    for (int b = 0; b < NBEATS; b++) begin
      e.data = d[b*BEAT_W +: BEAT_W];
      e.sof  = (model_row == 0) && (b == 0);
      e.eol  = (b == NBEATS - 1);
      e.eof  = e.eol && (model_row == H - 1);
      e.par  = ^e.data;
      sb.push_back(e);
    end
    model_row = (model_row == H - 1) ? 0 : model_row + 1;
  endtask

  // Returns #1 after the edge that accepted the row.
  task automatic offer_row(input logic [ROW_W-1:0] d);
    int n;
    row_data  = d;
    row_valid = 1'b1;
    n = 0;
    while (!row_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests = tests + 1;
    if (!row_ready) begin
      fails = fails + 1;
      $display("FAIL offer_timeout row_ready=%b after %0d cycles exp 1", row_ready, n);
    end
    @(posedge clk); #1;
    row_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    tests = tests + 1;
    if (sb.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain_timeout pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    row_valid = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    model_row = 0;
    reset     = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests = tests + 4;
    if (row_ready !== 1'b1) begin
      fails = fails + 1; $display("FAIL reset_row_ready got %b exp 1", row_ready);
    end
    if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eol !== 1'b0 || out_eof !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL reset_flags got valid=%b sof=%b eol=%b eof=%b exp 0000", out_valid, out_sof, out_eol, out_eof);
    end
    if (out_data !== '0) begin
      fails = fails + 1; $display("FAIL reset_data got %h exp 0", out_data);
    end
    if (frame_count !== 16'd0) begin
      fails = fails + 1; $display("FAIL reset_frame_count got %0d exp 0", frame_count);
    end
`ifdef PIXEL_TX_PARITY_EN
    tests = tests + 1;
    if (out_parity !== 1'b0) begin
      fails = fails + 1; $display("FAIL reset_parity got %b exp 0", out_parity);
    end
`endif
    reset = 1'b1;
    model_row = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests = tests + 1;
      if (out_valid !== 1'b0 || row_ready !== 1'b1) begin
        fails = fails + 1;
        $display("FAIL idle_no_beat got valid=%b row_ready=%b exp 0 1", out_valid, row_ready);
      end
    end
  endtask

  task automatic test_single_row();
    logic [ROW_W-1:0] d;
    d = make_row(0);
    out_ready = 1'b1;
    push_row(d);
    offer_row(d);
    for (int k = 0; k < NBEATS; k++) begin
      tests = tests + 1;
      if (out_valid !== 1'b1) begin
        fails = fails + 1; $display("FAIL single_gapless beat %0d got valid=%b exp 1", k, out_valid);
      end
      @(posedge clk); #1;
    end
    tests = tests + 2;
    if (out_valid !== 1'b0 || row_ready !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL single_idle got valid=%b row_ready=%b exp 0 1", out_valid, row_ready);
    end
    if (sb.size() != 0) begin
      fails = fails + 1; $display("FAIL single_all_beats pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [ROW_W-1:0] d;
    int c0;
    do_reset();
    d = make_row(0);
    push_row(d);
    offer_row(d);
    c0 = cyc;
    for (int r = 1; r <= 3; r++) begin
      d = make_row(32 * r);
      push_row(d);
      offer_row(d);
    end
    tests = tests + 2;
    if (cyc - c0 !== 9) begin
      fails = fails + 1; $display("FAIL b2b_throughput got %0d cycles exp 9", cyc - c0);
    end
    if (frame_count !== 16'd1) begin
      fails = fails + 1; $display("FAIL b2b_frame_count got %0d exp 1", frame_count);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [ROW_W-1:0] d;
    d = make_row(0);
    out_ready = 1'b1;
    push_row(d);
    offer_row(d);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests = tests + 3;
      if (out_valid !== 1'b1 || out_data !== d[BEAT_W +: BEAT_W]) begin
        fails = fails + 1;
        $display("FAIL bp_hold_data cycle %0d got valid=%b data=%h exp 1 %h", k, out_valid, out_data, d[BEAT_W +: BEAT_W]);
      end
      if (out_sof !== 1'b0 || out_eol !== 1'b0 || out_eof !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL bp_hold_flags cycle %0d got sof=%b eol=%b eof=%b exp 000", k, out_sof, out_eol, out_eof);
      end
      if (row_ready !== 1'b0) begin
        fails = fails + 1; $display("FAIL bp_row_ready cycle %0d got %b exp 0", k, row_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests = tests + 1;
    if (out_valid !== 1'b1 || out_data !== d[2*BEAT_W +: BEAT_W] || out_eol !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL bp_resume got valid=%b data=%h eol=%b exp 1 %h 1", out_valid, out_data, out_eol, d[2*BEAT_W +: BEAT_W]);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_frame();
    logic [ROW_W-1:0] d;
    do_reset();
    d = make_row(100);
    push_row(d);
    offer_row(d);
    wait_drain();
    d = make_row(150);
    push_row(d);
    offer_row(d);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests = tests + 4;
    if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eol !== 1'b0 || out_eof !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL midrst_flags got valid=%b sof=%b eol=%b eof=%b exp 0000", out_valid, out_sof, out_eol, out_eof);
    end
    if (row_ready !== 1'b1) begin
      fails = fails + 1; $display("FAIL midrst_row_ready got %b exp 1", row_ready);
    end
    if (out_data !== '0) begin
      fails = fails + 1; $display("FAIL midrst_data got %h exp 0", out_data);
    end
    if (frame_count !== 16'd0) begin
      fails = fails + 1; $display("FAIL midrst_frame_count got %0d exp 0", frame_count);
    end
    sb.delete();
    model_row = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    d = make_row(200);
    push_row(d);
    offer_row(d);
    tests = tests + 1;
    if (out_valid !== 1'b1 || out_sof !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL midrst_sof got valid=%b sof=%b exp 1 1", out_valid, out_sof);
    end
    wait_drain();
    tests = tests + 1;
    if (frame_count !== 16'd0) begin
      fails = fails + 1; $display("FAIL midrst_frame_after got %0d exp 0", frame_count);
    end
  endtask

`ifdef PIXEL_TX_PARITY_EN
  task automatic test_parity();
    logic [ROW_W-1:0] d;
    logic             exp_par;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 24; i++) d[i*8 +: 8] = 8'h01;
      if (t == 1) d[3*8 +: 8] = 8'h03;
      push_row(d);
      offer_row(d);
      for (int k = 0; k < NBEATS; k++) begin
        exp_par = (t == 1 && k == 0);
        tests = tests + 1;
        if (out_parity !== exp_par) begin
          fails = fails + 1;
          $display("FAIL parity row %0d beat %0d got %b exp %b", t, k, out_parity, exp_par);
        end
        @(posedge clk); #1;
      end
      wait_drain();
    end
  endtask
`endif

  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    model_row = 0;
    reset     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
`ifdef PIXEL_TX_PARITY_EN
    test_parity();
`endif
    tests = tests + 1;
    if (sb.size() != 0) begin
      fails = fails + 1; $display("FAIL final_scoreboard pending=%0d exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
